exec_datapath: RTL

- Execute-stage datapath directly downstream of the control unit.
- Consumes the control strobes (we_a, we_b, alu_op, do_alu, do_store) and the 4-bit immediate field (instr[3:0]).
- Holds accumulator A and operand register B, and performs ALU operations; MUL is iterative and multi-cycle.
- Drives a one-deep store port to data memory with a valid/ready handshake, and returns the zero flag used for BEQ.

---
 rtl/exec_datapath_if.sv | 14 +
 rtl/exec_datapath.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/exec_datapath_if.sv
// Store port from the execute datapath to data memory.
// The datapath is the master: it drives valid/addr/data and samples ready.
interface exec_datapath_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              store_valid;
   logic              store_ready;
   logic [ADDR_W-1:0] store_addr;
   logic [DATA_W-1:0] store_data;

   modport master (output store_valid, output store_addr, output store_data, input store_ready);
   modport slave  (input store_valid, input store_addr, input store_data, output store_ready);
endinterface

// File: rtl/exec_datapath.sv
// Execute-stage datapath: A/B registers, ALU with iterative shift-add MUL,
// zero flag for BEQ, and a one-deep valid/ready store port.
module exec_datapath #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [2:0]        alu_op,
   input  logic              do_alu,
   input  logic              do_store,
   input  logic [3:0]        imm,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_b,
   output logic              zero,
   output logic              busy,
   output logic              cmd_drop,
   exec_datapath_if.master   store
);
   localparam int CNT_W = $clog2(DATA_W);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   typedef enum logic {IDLE, MUL} alu_state_t;
   typedef enum logic {S_IDLE, S_PEND} st_state_t;

   alu_state_t a_state, a_next;
   st_state_t  s_state, s_next;

   logic [DATA_W-1:0] alu_res, mcand, mplier, acc, acc_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] st_data;
   logic              any_cmd, mul_start, mul_last, st_go, drop;

   assign busy      = (a_state == MUL);
   assign any_cmd   = we_a | we_b | do_alu | do_store;
   assign mul_start = !busy && do_alu && (alu_op == OP_MUL);
   assign mul_last  = busy && (cnt == CNT_W'(DATA_W-1));
   assign st_go     = !busy && do_store && (s_state == S_IDLE);
   // Busy swallows every command; otherwise drops come from A-write or store-port conflicts.
   assign drop      = (busy && any_cmd)
                    | (!busy && we_a && do_alu)
                    | (!busy && do_store && (s_state == S_PEND));
   assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

   assign store.store_valid = (s_state == S_PEND);
   assign store.store_addr  = st_addr;
   assign store.store_data  = st_data;

   always_comb begin
      alu_res = reg_a;
      unique case (alu_op)
         OP_ADD:  alu_res = reg_a + reg_b;
         OP_SUB:  alu_res = reg_a - reg_b;
         OP_AND:  alu_res = reg_a & reg_b;
         OP_OR:   alu_res = reg_a | reg_b;
         OP_SHL:  alu_res = {reg_a[DATA_W-2:0], 1'b0};
         OP_SHR:  alu_res = {1'b0, reg_a[DATA_W-1:1]};
         default: alu_res = reg_a;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_state <= IDLE;
         s_state <= S_IDLE;
      end else begin
         a_state <= a_next;
         s_state <= s_next;
      end
   end

   always_comb begin
      a_next = a_state;
      s_next = s_state;
      unique case (a_state)
         IDLE: if (mul_start) a_next = MUL;
         MUL:  if (mul_last)  a_next = IDLE;
         default: a_next = IDLE;
      endcase
      unique case (s_state)
         S_IDLE: if (st_go) s_next = S_PEND;
         S_PEND: if (store.store_ready) s_next = S_IDLE;
         default: s_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_a    <= '0;
         reg_b    <= '0;
         zero     <= 1'b0;
         cmd_drop <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         st_addr  <= '0;
         st_data  <= '0;
      end else begin
         if (drop) cmd_drop <= 1'b1;
         if (st_go) begin
            st_data <= reg_a;
            st_addr <= ADDR_W'(imm);
         end
         if (!busy) begin
            if (we_b) reg_b <= DATA_W'(imm);
            if (do_alu) begin
               if (alu_op == OP_MUL) begin
                  mcand  <= reg_a;
                  mplier <= reg_b;
                  acc    <= '0;
                  cnt    <= '0;
               end else begin
                  if (alu_op != OP_CMP) reg_a <= alu_res;
                  zero <= (alu_op == OP_CMP) ? (reg_a == reg_b) : (alu_res == '0);
               end
            end else if (we_a) begin
               reg_a <= DATA_W'(imm);
            end
         end else begin
            // One partial product per cycle; product is truncated to DATA_W bits.
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
               reg_a <= acc_nxt;
               zero  <= (acc_nxt == '0);
            end
         end
      end
   end
endmodule
